// File: rtl/mem_bist_pkg.sv
// Shared types and helpers for the memory BIST initiator.
// Address helpers work on MAX_W-bit values; callers size-cast to their own widths (<= 31 bits).
package mem_bist_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE    = 3'd0;
    localparam state_t WR_REQ  = 3'd1;
    localparam state_t WR_WAIT = 3'd2;
    localparam state_t RD_REQ  = 3'd3;
    localparam state_t RD_WAIT = 3'd4;
    localparam state_t DONE    = 3'd5;

    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] pattern(input logic [MAX_W-1:0] addr,
                                                 input logic [MAX_W-1:0] seed);
        return addr ^ seed;
    endfunction

    // One extra bit so stepping past the top of the address space is visible, not wrapped.
    function automatic logic [MAX_W:0] first_addr(input logic [MAX_W-1:0] start,
                                                  input logic [MAX_W-1:0] io);
        return (start == io) ? ({1'b0, start} + (MAX_W+1)'(1)) : {1'b0, start};
    endfunction

    function automatic logic [MAX_W:0] next_addr(input logic [MAX_W-1:0] cur,
                                                 input logic [MAX_W-1:0] io);
        logic [MAX_W:0] n;
        n = {1'b0, cur} + (MAX_W+1)'(1);
        if (n == {1'b0, io})
            n = n + (MAX_W+1)'(1);
        return n;
    endfunction

    function automatic int tmo_cnt_w(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mem_bist_req_port.sv
// Single-outstanding request port toward mem_cntrl, with a completion timeout.
// go loads a new request; completion and timeout are reported combinationally.
module mem_req_port
    import mem_bist_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_r_en,
    output logic                  mem_w_en,
    input  logic                  mem_rdy,
    input  logic                  mem_cplt,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  cplt,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  tmo
);

    localparam int TW = tmo_cnt_w(TIMEOUT);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic          waiting;
    logic [TW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr    <= '0;
            mem_data_in <= '0;
            mem_r_en    <= 1'b0;
            mem_w_en    <= 1'b0;
            waiting     <= 1'b0;
            cnt         <= '0;
        end else if (go) begin
            mem_addr    <= addr;
            mem_data_in <= data;
            mem_w_en    <= wr;
            mem_r_en    <= !wr;
        end else if ((mem_w_en || mem_r_en) && mem_rdy) begin
            // Accepted: drop the strobe, keep address/data until completion
            mem_w_en <= 1'b0;
            mem_r_en <= 1'b0;
            waiting  <= 1'b1;
            cnt      <= '0;
        end else if (waiting) begin
            if (mem_cplt || cnt == LAST)
                waiting <= 1'b0;
            else
                cnt <= cnt + TW'(1);
        end
    end

    assign cplt  = waiting && mem_cplt;
    assign tmo   = waiting && !mem_cplt && (cnt == LAST);
    assign rdata = mem_data_out;

endmodule

// File: rtl/mem_bist.sv
// Memory BIST initiator: writes P(a)=a^seed over a range, reads it back and compares.
// Acts as an alternate requester on the mem_cntrl interface.
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR    = 16'h0101,
    parameter int                    TIMEOUT    = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr_start,
    input  logic [ADDR_WIDTH-1:0] addr_end,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_r_en,
    output logic                  mem_w_en,
    input  logic                  mem_rdy,
    input  logic                  mem_cplt,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur, end_q, first_q;
    logic [DATA_WIDTH-1:0] seed_q, go_seed, go_data, rdata;
    logic [ADDR_WIDTH:0]   first_w, nxt_w;
    logic [ADDR_WIDTH-1:0] go_addr;
    logic                  empty, last, mismatch, go, go_wr, cplt, tmo;

    assign first_w  = (ADDR_WIDTH+1)'(first_addr(MAX_W'(addr_start), MAX_W'(IO_ADDR)));
    assign empty    = first_w > {1'b0, addr_end};
    assign nxt_w    = (ADDR_WIDTH+1)'(next_addr(MAX_W'(cur), MAX_W'(IO_ADDR)));
    // Compare against the end before stepping so an all-ones end never wraps
    assign last     = (cur == end_q) || (nxt_w > {1'b0, end_q});
    assign mismatch = rdata != DATA_WIDTH'(pattern(MAX_W'(cur), MAX_W'(seed_q)));

    always_comb begin
        go      = 1'b0;
        go_wr   = 1'b0;
        go_addr = cur;
        case (state)
            IDLE: if (start && !empty) begin
                go      = 1'b1;
                go_wr   = 1'b1;
                go_addr = first_w[ADDR_WIDTH-1:0];
            end
            WR_WAIT: if (cplt) begin
                go      = 1'b1;
                go_wr   = !last;
                go_addr = last ? first_q : nxt_w[ADDR_WIDTH-1:0];
            end
            RD_WAIT: if (cplt && !last) begin
                go      = 1'b1;
                go_addr = nxt_w[ADDR_WIDTH-1:0];
            end
            default: ;
        endcase
        go_seed = (state == IDLE) ? seed : seed_q;
        go_data = DATA_WIDTH'(pattern(MAX_W'(go_addr), MAX_W'(go_seed)));
    end

    always_ff @(posedge clk) begin
        if (go)
            cur <= go_addr;
        if (state == IDLE && start) begin
            end_q   <= addr_end;
            first_q <= first_w[ADDR_WIDTH-1:0];
            seed_q  <= seed;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    pass      <= empty;
                    timeout   <= 1'b0;
                    err_count <= '0;
                    fail_addr <= '0;
                    fail_data <= '0;
                    state     <= empty ? DONE : WR_REQ;
                end
                WR_REQ: if (mem_w_en && mem_rdy) state <= WR_WAIT;
                WR_WAIT: begin
                    if (tmo) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                        state   <= DONE;
                    end else if (cplt) begin
                        state <= last ? RD_REQ : WR_REQ;
                    end
                end
                RD_REQ: if (mem_r_en && mem_rdy) state <= RD_WAIT;
                RD_WAIT: begin
                    if (tmo) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                        state   <= DONE;
                    end else if (cplt) begin
                        if (mismatch) begin
                            if (err_count != 16'hFFFF)
                                err_count <= err_count + 16'd1;
                            if (err_count == 16'd0) begin
                                fail_addr <= cur;
                                fail_data <= rdata;
                            end
                        end
                        if (last) begin
                            pass  <= (err_count == 16'd0) && !mismatch;
                            state <= DONE;
                        end else begin
                            state <= RD_REQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    mem_req_port #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) u_port (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .wr          (go_wr),
        .addr        (go_addr),
        .data        (go_data),
        .mem_addr    (mem_addr),
        .mem_data_in (mem_data_in),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .mem_rdy     (mem_rdy),
        .mem_cplt    (mem_cplt),
        .mem_data_out(mem_data_out),
        .cplt        (cplt),
        .rdata       (rdata),
        .tmo         (tmo)
    );

endmodule

// File: tb/tb_mem_bist.sv
// Directed bench for mem_bist against a small behavioural memory with a fixed completion delay.
module tb_mem_bist;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] addr_start = '0, addr_end = '0, seed = '0;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count, fail_addr, fail_data;
    logic [15:0] mem_addr, mem_data_in;
    logic        mem_r_en, mem_w_en;
    logic        mem_rdy = 1'b1;
    logic        mem_cplt = 1'b0;
    logic [15:0] mem_data_out = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_bist #(
        .ADDR_WIDTH(16), .DATA_WIDTH(16), .IO_ADDR(16'h0101), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .addr_start(addr_start), .addr_end(addr_end),
        .seed(seed), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .mem_rdy(mem_rdy), .mem_cplt(mem_cplt),
        .mem_data_out(mem_data_out)
    );

    // Memory model: accept when rdy, complete three edges later unless suppressed
    logic [15:0] mem [0:65535];
    logic [15:0] pend_addr = '0;
    int          cd = 0;
    bit          no_cplt = 1'b0, flip_en = 1'b0, io_hit = 1'b0, both_en = 1'b0;
    logic [15:0] flip_addr = 16'h0002;
    logic [15:0] log_addr[$];
    logic [15:0] log_data[$];
    bit          log_wr[$];
    int          done_cnt = 0;

    always @(posedge clk) begin
        mem_cplt <= 1'b0;
        if (rst) begin
            cd <= 0;
        end else if ((mem_w_en || mem_r_en) && mem_rdy) begin
            pend_addr <= mem_addr;
            if (mem_w_en) mem[mem_addr] <= mem_data_in;
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_data_in);
            log_wr.push_back(mem_w_en);
            cd <= 2;
        end else if (cd != 0) begin
            cd <= cd - 1;
            if (cd == 1 && !no_cplt) begin
                mem_cplt     <= 1'b1;
                mem_data_out <= mem[pend_addr] ^ {15'd0, (flip_en && pend_addr == flip_addr)};
            end
        end
        if (mem_w_en && mem_r_en) both_en <= 1'b1;
        if ((mem_w_en || mem_r_en) && mem_addr == 16'h0101) io_hit <= 1'b1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_wr.delete();
    endtask

    task automatic launch(input logic [15:0] s, input logic [15:0] e, input logic [15:0] sd);
        @(negedge clk);
        addr_start = s;
        addr_end   = e;
        seed       = sd;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int budget, output int cyc, output bit ok);
        cyc = c0;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        ok = (done === 1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if ({busy, done, pass, timeout} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {busy, done, pass, timeout}); end
        total++; if ({mem_r_en, mem_w_en} !== 2'b0) begin bad++; $display("FAIL reset_en got=%b want=00", {mem_r_en, mem_w_en}); end
        total++; if ({err_count, fail_addr, fail_data, mem_addr} !== 64'd0) begin bad++; $display("FAIL reset_regs got=%h want=0", {err_count, fail_addr, fail_data, mem_addr}); end
        rst = 1'b0;
    endtask

    task automatic test_basic(input bit flip);
        int cyc; bit ok;
        logic [15:0] wdat [4];
        wdat = '{16'hA5A5, 16'hA5A4, 16'hA5A7, 16'hA5A6};
        clear_log();
        flip_en = flip;
        launch(16'h0000, 16'h0003, 16'hA5A5);
        wait_done(1, 200, cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_done got=%0d want=1", ok); end
        total++; if (log_addr.size() != 8) begin bad++; $display("FAIL basic_count got=%0d want=8", log_addr.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < log_addr.size()) begin
                total++;
                if (log_addr[i] !== 16'(i % 4) || log_wr[i] !== (i < 4) || (i < 4 && log_data[i] !== wdat[i])) begin
                    bad++;
                    $display("FAIL basic_access%0d got=%h/%0d/%h want=%h/%0d/%h", i, log_addr[i], log_wr[i], log_data[i], 16'(i % 4), (i < 4), wdat[i % 4]);
                end
            end
        end
        if (!flip) begin
            total++; if (pass !== 1'b1 || err_count !== 16'd0) begin bad++; $display("FAIL basic_pass got=%b/%h want=1/0000", pass, err_count); end
        end else begin
            total++; if (pass !== 1'b0 || err_count !== 16'd1) begin bad++; $display("FAIL flip_pass got=%b/%h want=0/0001", pass, err_count); end
            total++; if (fail_addr !== 16'h0002 || fail_data !== 16'hA5A6) begin bad++; $display("FAIL flip_fail got=%h/%h want=0002/A5A6", fail_addr, fail_data); end
        end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b%b want=00", done, busy); end
        flip_en = 1'b0;
    endtask

    task automatic test_io_skip();
        int cyc; bit ok;
        logic [15:0] ea [6];
        ea = '{16'h00FF, 16'h0100, 16'h0102, 16'h00FF, 16'h0100, 16'h0102};
        clear_log();
        io_hit = 1'b0;
        launch(16'h00FF, 16'h0102, 16'h0000);
        wait_done(1, 200, cyc, ok);
        total++; if (!ok || pass !== 1'b1) begin bad++; $display("FAIL io_done got=%0d/%b want=1/1", ok, pass); end
        total++; if (log_addr.size() != 6) begin bad++; $display("FAIL io_count got=%0d want=6", log_addr.size()); end
        for (int i = 0; i < 6; i++) begin
            if (i < log_addr.size()) begin
                total++;
                if (log_addr[i] !== ea[i] || log_wr[i] !== (i < 3)) begin bad++; $display("FAIL io_access%0d got=%h want=%h", i, log_addr[i], ea[i]); end
            end
        end
        total++; if (io_hit !== 1'b0) begin bad++; $display("FAIL io_hit got=%b want=0", io_hit); end
    endtask

    task automatic test_rdy_stall();
        int cyc; bit ok; bit stable;
        clear_log();
        mem_rdy = 1'b0;
        launch(16'h0010, 16'h0010, 16'h1234);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (mem_w_en !== 1'b1 || mem_r_en !== 1'b0 || mem_addr !== 16'h0010 || mem_data_in !== 16'h1224) stable = 1'b0;
            @(negedge clk);
        end
        total++; if (!stable) begin bad++; $display("FAIL stall_stable got=%b want=1", stable); end
        mem_rdy = 1'b1;
        @(negedge clk);
        total++; if (mem_w_en !== 1'b0 || log_addr.size() != 1) begin bad++; $display("FAIL stall_accept got=%b/%0d want=0/1", mem_w_en, log_addr.size()); end
        wait_done(1, 200, cyc, ok);
        total++; if (!ok || timeout !== 1'b0 || pass !== 1'b1) begin bad++; $display("FAIL stall_result got=%0d/%b/%b want=1/0/1", ok, timeout, pass); end
    endtask

    task automatic test_timeout();
        int cyc; bit ok;
        clear_log();
        no_cplt = 1'b1;
        launch(16'h0020, 16'h0023, 16'h0000);
        total++; if (mem_w_en !== 1'b1) begin bad++; $display("FAIL tmo_req got=%b want=1", mem_w_en); end
        @(negedge clk);
        total++; if (mem_w_en !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL tmo_endrop got=%b/%b want=0/1", mem_w_en, busy); end
        wait_done(2, 100, cyc, ok);
        total++; if (!ok || cyc != 18) begin bad++; $display("FAIL tmo_latency got=%0d want=18", cyc); end
        total++; if (timeout !== 1'b1 || pass !== 1'b0 || log_addr.size() != 1) begin bad++; $display("FAIL tmo_flags got=%b/%b/%0d want=1/0/1", timeout, pass, log_addr.size()); end
        no_cplt = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_top_range();
        int cyc; bit ok;
        clear_log();
        launch(16'hFFFE, 16'hFFFF, 16'h0F0F);
        wait_done(1, 200, cyc, ok);
        total++; if (!ok || pass !== 1'b1 || timeout !== 1'b0) begin bad++; $display("FAIL top_done got=%0d/%b want=1/1", ok, pass); end
        total++; if (log_addr.size() != 4) begin bad++; $display("FAIL top_count got=%0d want=4", log_addr.size()); end
        if (log_addr.size() == 4) begin
            total++;
            if ({log_addr[0], log_addr[1], log_addr[2], log_addr[3]} !== 64'hFFFE_FFFF_FFFE_FFFF || {log_wr[0], log_wr[1], log_wr[2], log_wr[3]} !== 4'b1100)
                begin bad++; $display("FAIL top_seq got=%h %h %h %h want=FFFE FFFF FFFE FFFF", log_addr[0], log_addr[1], log_addr[2], log_addr[3]); end
            total++; if (log_data[1] !== 16'hF0F0) begin bad++; $display("FAIL top_data got=%h want=F0F0", log_data[1]); end
        end
    endtask

    task automatic test_empty();
        int cyc; bit ok;
        clear_log();
        launch(16'h0005, 16'h0003, 16'h0000);
        wait_done(1, 1, cyc, ok);
        total++; if (!ok || pass !== 1'b1 || log_addr.size() != 0) begin bad++; $display("FAIL empty_rev got=%0d/%b/%0d want=1/1/0", ok, pass, log_addr.size()); end
        launch(16'h0101, 16'h0101, 16'h0000);
        wait_done(1, 1, cyc, ok);
        total++; if (!ok || pass !== 1'b1 || log_addr.size() != 0) begin bad++; $display("FAIL empty_io got=%0d/%b/%0d want=1/1/0", ok, pass, log_addr.size()); end
    endtask

    task automatic test_rst_mid();
        int n; int dc;
        clear_log();
        launch(16'h0040, 16'h0043, 16'h3C3C);
        n = 0;
        while (log_addr.size() < 5 && n < 200) begin @(negedge clk); n++; end
        total++; if (log_addr.size() != 5 || busy !== 1'b1) begin bad++; $display("FAIL rst_reach got=%0d/%b want=5/1", log_addr.size(), busy); end
        dc = done_cnt;
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || mem_r_en !== 1'b0) begin bad++; $display("FAIL rst_wait got=%b/%b want=0/0", busy, mem_r_en); end
        @(negedge clk);
        rst = 1'b0;
        clear_log();
        launch(16'h0040, 16'h0043, 16'h3C3C);
        n = 0;
        while (log_addr.size() < 4 && n < 200) begin @(negedge clk); n++; end
        mem_rdy = 1'b0;
        n = 0;
        while (mem_r_en !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        total++; if (mem_r_en !== 1'b1 || mem_addr !== 16'h0040) begin bad++; $display("FAIL rst_rdreq got=%b/%h want=1/0040", mem_r_en, mem_addr); end
        #2 rst = 1'b1;
        #1;
        total++; if (mem_r_en !== 1'b0 || busy !== 1'b0 || mem_addr !== 16'h0000) begin bad++; $display("FAIL rst_async got=%b/%b/%h want=0/0/0000", mem_r_en, busy, mem_addr); end
        @(negedge clk);
        rst = 1'b0;
        mem_rdy = 1'b1;
        repeat (8) @(negedge clk);
        total++; if (done_cnt != dc || busy !== 1'b0) begin bad++; $display("FAIL rst_nodone got=%0d want=%0d", done_cnt, dc); end
    endtask

    task automatic test_back_to_back();
        int cyc; bit ok; int dc;
        clear_log();
        dc = done_cnt;
        launch(16'h0000, 16'h0001, 16'h1111);
        repeat (3) @(negedge clk);
        addr_start = 16'h0050;
        addr_end   = 16'h0060;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, 200, cyc, ok);
        total++; if (!ok || pass !== 1'b1 || err_count !== 16'd0) begin bad++; $display("FAIL b2b_done got=%0d/%b/%h want=1/1/0000", ok, pass, err_count); end
        total++; if (log_addr.size() != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4", log_addr.size()); end
        if (log_addr.size() == 4) begin
            total++;
            if ({log_addr[0], log_addr[1], log_addr[2], log_addr[3]} !== 64'h0000_0001_0000_0001 || log_data[0] !== 16'h1111 || log_data[1] !== 16'h1110)
                begin bad++; $display("FAIL b2b_seq got=%h %h %h %h d=%h %h want=0 1 0 1 d=1111 1110", log_addr[0], log_addr[1], log_addr[2], log_addr[3], log_data[0], log_data[1]); end
        end
        repeat (40) @(negedge clk);
        total++; if (done_cnt != dc + 1 || busy !== 1'b0 || log_addr.size() != 4) begin bad++; $display("FAIL b2b_ignored got=%0d/%b/%0d want=%0d/0/4", done_cnt - dc, busy, log_addr.size(), 1); end
        total++; if (both_en !== 1'b0) begin bad++; $display("FAIL both_en got=%b want=0", both_en); end
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_basic(1'b1);
        test_io_skip();
        test_rdy_stall();
        test_timeout();
        test_top_range();
        test_empty();
        test_rst_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "bench time limit");
    end

endmodule

// File: doc/mem_bist.md
Name: mem_bist

Overview:
- Memory built-in self-test initiator.
- Drives the requester side of the mem_cntrl high-level interface: mem_addr, mem_data_in, mem_r_en and mem_w_en out; mem_rdy, mem_cplt and mem_data_out in.
- Writes a seeded pattern across a programmable address range, then reads the range back and compares.
- Reports pass/fail, the first failing address/data and an error count. Sits beside the CPU as an alternate master, muxed at board top.

Parameters:
ADDR_WIDTH, 16, memory address width
DATA_WIDTH, 16, memory data width
IO_ADDR, 16'h0101, memory-mapped IO address; never accessed by the test
TIMEOUT, 1024, max cycles from request acceptance to mem_cplt

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse; begins a test when idle
addr_start  input  ADDR_WIDTH  first address, sampled on start
addr_end  input  ADDR_WIDTH  last address (inclusive), sampled on start
seed  input  DATA_WIDTH  pattern seed, sampled on start
busy  output  1  test in progress
done  output  1  one-cycle pulse at test end
pass  output  1  last test had zero mismatches and no timeout; held until next start
timeout  output  1  last test aborted on timeout; held until next start
err_count  output  16  mismatches in last test, saturating at 16'hFFFF
fail_addr  output  ADDR_WIDTH  address of first mismatch
fail_data  output  DATA_WIDTH  data read at first mismatch
mem_addr  output  ADDR_WIDTH  request address
mem_data_in  output  DATA_WIDTH  write data
mem_r_en  output  1  read request
mem_w_en  output  1  write request
mem_rdy  input  1  controller can accept a request
mem_cplt  input  1  one-cycle completion pulse
mem_data_out  input  DATA_WIDTH  read data, valid when mem_cplt is high

Behaviour:
- Reset: all outputs 0; state IDLE. Reset mid-test drops mem_r_en/mem_w_en immediately (asynchronous) and discards the test; no done pulse.
- Pattern: P(a) = zero-extend/truncate(a) to DATA_WIDTH, XOR seed.
- Handshake:
  - Only one outstanding request.
  - en, mem_addr and mem_data_in are asserted together and held stable until a rising edge where en && mem_rdy (acceptance).
  - en deasserts the cycle after acceptance; mem_addr and mem_data_in stay held until mem_cplt.
  - The next request is issued no earlier than the cycle after mem_cplt.
  - mem_r_en and mem_w_en are never high together.
- States:
  - IDLE: start -> latch inputs, clear pass/timeout/err_count/fail_*, busy=1, cur=addr_start; go to WR_REQ.
  - WR_REQ: assert mem_w_en, data=P(cur); on acceptance -> WR_WAIT.
  - WR_WAIT: on mem_cplt -> if cur==addr_end go to RD_REQ with cur=addr_start, else cur=next, stay in WR_REQ.
  - RD_REQ: assert mem_r_en; on acceptance -> RD_WAIT.
  - RD_WAIT: on mem_cplt, compare mem_data_out with P(cur).
    - On mismatch: err_count++ (saturating); on the first mismatch also capture fail_addr/fail_data.
    - Advance as in WR_WAIT; after the last address -> DONE.
  - DONE: busy=0, done=1 for one cycle, pass=(err_count==0); go to IDLE.
- next: cur+1, skipping IO_ADDR. If IO_ADDR is addr_start, the start is moved past it. If the only address in range is IO_ADDR, zero accesses occur.
- addr_end < addr_start: no accesses; DONE on the cycle after start; pass=1.
- addr_end = all ones: compare before incrementing; the counter must never wrap to 0 and continue.
- Timeout:
  - Counter starts at acceptance; if TIMEOUT cycles pass without mem_cplt, deassert en, set timeout=1, pass=0, go to DONE.
  - Waiting for mem_rdy is not timed.
- start while busy is ignored. mem_cplt in IDLE or in a REQ state is ignored.
- Latency per access: 1 cycle request + controller latency + 1 cycle turnaround.

Decomposition:
- Package mem_bist_pkg holds:
  - state enum (IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DONE)
  - pattern function P
  - next-address function with IO skip
  - timeout counter width derived from TIMEOUT
- Sub-module mem_req_port covers one request's handshake plus the timeout counter. Inputs: go, wr, addr, data. Outputs: mem_* drive, cplt, rdata, tmo. mem_bist sequences it.

Test Plan:
- Range 0x0000-0x0003, seed 0xA5A5, ideal memory model (rdy=1, cplt 3 cycles after accept) -> 4 writes with data 0xA5A5/0xA5A4/0xA5A7/0xA5A6, then 4 reads; done pulse; pass=1; err_count=0.
- Same test, model flips bit 0 at address 0x0002 -> err_count=1, fail_addr=0x0002, fail_data=0xA5A6, pass=0.
- Range 0x00FF-0x0102 -> accesses only 0x00FF, 0x0100, 0x0102; mem_addr never equals 0x0101.
- mem_rdy held low 20 cycles during WR_REQ -> mem_w_en and mem_addr stay stable all 20 cycles; accepted on the first high rdy; no timeout.
- Model never asserts cplt, TIMEOUT=16 -> en drops after acceptance; done 16 cycles later (+1); timeout=1, pass=0. Range 0xFFFE-0xFFFF completes exactly 2+2 accesses.
- rst asserted during RD_WAIT -> mem_r_en/busy go 0 asynchronously with no done pulse; the next start runs a clean test; start while busy has no effect.
